slc3_mem_sequencer: RTL and testbench

//  Memory access sequencer feeding the SLC-3 datapath's Data_to_CPU input (selected into MDR by MIO_EN).

---
 rtl/slc3_pkg.sv | 21 ++
 rtl/slc3_mem_sequencer.sv | 154 +++++++++++++++
 tb/tb_slc3_mem_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory sequencer.
package slc3_pkg;

    // Sequencer states: an SRAM access walks IDLE -> SETUP -> ACCESS -> DONE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Single memory-mapped I/O word (switches on read, hex display on write).
    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

    // Default SRAM address width of the board.
    localparam int SRAM_AW_DEF = 20;

    // Wait counter width; enough for WAIT_STATES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/slc3_mem_sequencer.sv
// SLC-3 memory access sequencer.
// Accepts one request in IDLE, latches MAR/MDR/we, then drives the SRAM
// strobes for SETUP, WAIT_STATES ACCESS cycles and a DONE hold cycle, which
// also pulses ack. Read data is registered into Data_to_CPU.
// Optional feature: define SLC3_MMIO_EN to map address 16'hFFFF to the board
// I/O (SW on read, HEX_Reg on write) with a short IDLE -> DONE path and no
// SRAM strobes. Without it, 16'hFFFF is ordinary SRAM and HEX_Reg is 0.
// WAIT_STATES must lie in 1..15.
module slc3_mem_sequencer
    import slc3_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [15:0]        MAR,
    input  logic [15:0]        MDR,
    input  logic               req,
    input  logic               we,
    output logic               ack,
    output logic               busy,
    output logic [15:0]        Data_to_CPU,
    output logic [SRAM_AW-1:0] ADDR,
    output logic               CE_N,
    output logic               OE_N,
    output logic               WE_N,
    output logic               UB_N,
    output logic               LB_N,
    output logic [15:0]        Data_to_SRAM,
    output logic               data_drive_en,
    input  logic [15:0]        Data_from_SRAM,
    input  logic [15:0]        SW,
    output logic [15:0]        HEX_Reg
);

    // ACCESS counts down from WAIT_STATES-1 to 0; the 0 cycle is the last one.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      mar_q, mar_d;
    logic [15:0]      mdr_q, mdr_d;
    logic             we_q, we_d;
    logic             mmio_q, mmio_d;
    logic [15:0]      dout_q, dout_d;
`ifdef SLC3_MMIO_EN
    logic [15:0]      hex_q, hex_d;
`endif
    logic             sram_sel;

    // State, counter and latched request registers; reset aborts any access.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            mmio_q  <= 1'b0;
            dout_q  <= '0;
`ifdef SLC3_MMIO_EN
            hex_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            we_q    <= we_d;
            mmio_q  <= mmio_d;
            dout_q  <= dout_d;
`ifdef SLC3_MMIO_EN
            hex_q   <= hex_d;
`endif
        end
    end

    // Next-state, latch updates and SRAM strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        we_d    = we_q;
        mmio_d  = mmio_q;
        dout_d  = dout_q;
`ifdef SLC3_MMIO_EN
        hex_d   = hex_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    mar_d   = MAR;
                    mdr_d   = MDR;
                    we_d    = we;
                    mmio_d  = 1'b0;
                    state_d = SETUP;
`ifdef SLC3_MMIO_EN
                    // I/O completes at acceptance so the value is ready with ack.
                    if (MAR == MMIO_ADDR) begin
                        mmio_d  = 1'b1;
                        state_d = DONE;
                        if (we) hex_d  = MDR;
                        else    dout_d = SW;
                    end
`endif
                end
            end
            SETUP: begin
                cnt_d   = CNT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) dout_d = Data_from_SRAM;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // req is deliberately not sampled here; IDLE takes the next one.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // CE_N and data drive span SETUP through DONE for setup/hold margin.
        sram_sel      = (state_q != IDLE) && !mmio_q;
        ack           = (state_q == DONE);
        busy          = (state_q != IDLE);
        CE_N          = !sram_sel;
        OE_N          = !((state_q == ACCESS) && !we_q);
        WE_N          = !((state_q == ACCESS) && we_q);
        UB_N          = !sram_sel;
        LB_N          = !sram_sel;
        data_drive_en = sram_sel && we_q;
    end

    assign ADDR         = SRAM_AW'(mar_q);
    assign Data_to_SRAM = mdr_q;
    assign Data_to_CPU  = dout_q;

`ifdef SLC3_MMIO_EN
    assign HEX_Reg = hex_q;
`else
    logic unused_sw;
    assign unused_sw = ^SW;
    assign HEX_Reg   = '0;
`endif

endmodule

// File: tb/tb_slc3_mem_sequencer.sv
// Self-checking bench for slc3_mem_sequencer: SRAM model, reference memory
// model and per-scenario tasks. Works with or without SLC3_MMIO_EN.
module tb_slc3_mem_sequencer;

    localparam int WS = 2;
`ifdef SLC3_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] MAR = '0, MDR = '0, SW = '0;
    logic        req = 1'b0, we = 1'b0;
    logic        ack, busy, CE_N, OE_N, WE_N, UB_N, LB_N, data_drive_en;
    logic [15:0] Data_to_CPU, Data_to_SRAM, Data_from_SRAM, HEX_Reg;
    logic [19:0] ADDR;

    int n_assert = 0;
    int n_fail   = 0;

    // backdoor port into the SRAM model
    logic        bk_we = 1'b0;
    logic [15:0] bk_a = '0, bk_d = '0;

    // reference model state
    logic [15:0] exp_mem [int];
    logic [15:0] exp_dout = '0;
    logic [15:0] exp_hex  = '0;

    always #5 Clk = ~Clk;

    slc3_mem_sequencer #(.WAIT_STATES(WS), .SRAM_AW(20)) dut (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .req(req), .we(we),
        .ack(ack), .busy(busy), .Data_to_CPU(Data_to_CPU), .ADDR(ADDR),
        .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
        .Data_to_SRAM(Data_to_SRAM), .data_drive_en(data_drive_en),
        .Data_from_SRAM(Data_from_SRAM), .SW(SW), .HEX_Reg(HEX_Reg)
    );

    // never-written SRAM cells hold an address-derived pattern
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A3C;
    endfunction

    // asynchronous SRAM model
    logic [15:0] sram   [0:65535];
    bit          sram_v [0:65535];
    always @(posedge Clk) begin
        if (bk_we) begin
            sram[bk_a]   <= bk_d;
            sram_v[bk_a] <= 1'b1;
        end else if (!CE_N && !WE_N) begin
            sram[ADDR[15:0]]   <= Data_to_SRAM;
            sram_v[ADDR[15:0]] <= 1'b1;
        end
    end
    assign Data_from_SRAM = (!CE_N && !OE_N)
        ? (sram_v[ADDR[15:0]] ? sram[ADDR[15:0]] : init_val(ADDR[15:0]))
        : 16'hDEAD;

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : init_val(a);
    endfunction

    task automatic backdoor(input logic [15:0] a, input logic [15:0] d);
        @(negedge Clk);
        bk_we = 1'b1; bk_a = a; bk_d = d;
        @(negedge Clk);
        bk_we = 1'b0;
        exp_mem[int'(a)] = d;
    endtask

    // One complete access from an idle sequencer, with full cycle-level checks.
    task automatic do_access(input string tag, input bit w, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] sw_v,
                             input logic [15:0] mar_after);
        bit mm;
        int lat, acks, ack_at, oe_c, we_c, ce_c, dde_c, busy_c;
        int both, addr_bad, dts_bad, ub_bad;
        logic [15:0] dout_at_ack;
        mm = MMIO_EN && (a == 16'hFFFF);
        lat = mm ? 1 : WS + 2;
        acks = 0; ack_at = -1; oe_c = 0; we_c = 0; ce_c = 0; dde_c = 0; busy_c = 0;
        both = 0; addr_bad = 0; dts_bad = 0; ub_bad = 0; dout_at_ack = 16'hxxxx;

        @(negedge Clk);
        req = 1'b1; we = w; MAR = a; MDR = d; SW = sw_v;
        @(posedge Clk);
        #1;
        req = 1'b0; we = ~w; MAR = mar_after; MDR = ~d;

        if (w) begin
            if (mm) exp_hex = d;
            else    exp_mem[int'(a)] = d;
        end else begin
            exp_dout = mm ? sw_v : exp_rd(a);
        end

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge Clk);
            if (ack) begin acks++; ack_at = k; dout_at_ack = Data_to_CPU; end
            if (!OE_N) oe_c++;
            if (!WE_N) we_c++;
            if (!CE_N) ce_c++;
            if (data_drive_en) dde_c++;
            if (busy) busy_c++;
            if (!OE_N && !WE_N) both++;
            if (!CE_N && ADDR !== {4'h0, a}) addr_bad++;
            if (data_drive_en && Data_to_SRAM !== d) dts_bad++;
            if (UB_N !== CE_N || LB_N !== CE_N) ub_bad++;
        end

        n_assert++;
        if (acks !== 1) begin n_fail++; $display("FAIL %s ack_count: got %0d want 1", tag, acks); end
        n_assert++;
        if (ack_at !== lat) begin n_fail++; $display("FAIL %s ack_cycle: got %0d want %0d", tag, ack_at, lat); end
        n_assert++;
        if (busy_c !== lat) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_c, lat); end
        n_assert++;
        if (oe_c !== ((!mm && !w) ? WS : 0)) begin n_fail++; $display("FAIL %s oe_low_cycles: got %0d want %0d", tag, oe_c, (!mm && !w) ? WS : 0); end
        n_assert++;
        if (we_c !== ((!mm && w) ? WS : 0)) begin n_fail++; $display("FAIL %s we_low_cycles: got %0d want %0d", tag, we_c, (!mm && w) ? WS : 0); end
        n_assert++;
        if (ce_c !== (mm ? 0 : WS + 2)) begin n_fail++; $display("FAIL %s ce_low_cycles: got %0d want %0d", tag, ce_c, mm ? 0 : WS + 2); end
        n_assert++;
        if (dde_c !== ((!mm && w) ? WS + 2 : 0)) begin n_fail++; $display("FAIL %s drive_cycles: got %0d want %0d", tag, dde_c, (!mm && w) ? WS + 2 : 0); end
        n_assert++;
        if (both + addr_bad + dts_bad + ub_bad !== 0) begin
            n_fail++;
            $display("FAIL %s bus_rules: oe_we_overlap=%0d addr_err=%0d wdata_err=%0d byte_en_err=%0d want all 0",
                     tag, both, addr_bad, dts_bad, ub_bad);
        end
        n_assert++;
        if (dout_at_ack !== exp_dout) begin n_fail++; $display("FAIL %s data_to_cpu: got %h want %h", tag, dout_at_ack, exp_dout); end
        n_assert++;
        if (HEX_Reg !== exp_hex) begin n_fail++; $display("FAIL %s hex_reg: got %h want %h", tag, HEX_Reg, exp_hex); end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_assert++;
        if ({ack, busy, CE_N, OE_N, WE_N, UB_N, LB_N, data_drive_en} !== 8'b00111110) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00111110", {ack, busy, CE_N, OE_N, WE_N, UB_N, LB_N, data_drive_en});
        end
        n_assert++;
        if ({Data_to_CPU, HEX_Reg, Data_to_SRAM, ADDR} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: cpu=%h hex=%h wdata=%h addr=%h want all 0", Data_to_CPU, HEX_Reg, Data_to_SRAM, ADDR);
        end
        Reset = 1'b0;
        exp_dout = '0;
        exp_hex  = '0;
        @(negedge Clk);
    endtask

    task automatic test_reset_abort();
        int acks;
        @(negedge Clk);
        req = 1'b1; we = 1'b1; MAR = 16'h0100; MDR = 16'h7777;
        @(posedge Clk);
        #1 req = 1'b0;
        repeat (2) @(negedge Clk);
        n_assert++;
        if (WE_N !== 1'b0) begin n_fail++; $display("FAIL abort_in_access: WE_N got %b want 0", WE_N); end
        #2 Reset = 1'b1;
        #1;
        n_assert++;
        if ({WE_N, CE_N, ack, busy, data_drive_en} !== 5'b11000) begin
            n_fail++;
            $display("FAIL abort_async: WE_N,CE_N,ack,busy,dde got %b want 11000", {WE_N, CE_N, ack, busy, data_drive_en});
        end
        @(negedge Clk);
        Reset = 1'b0;
        exp_dout = '0;
        exp_hex  = '0;
        acks = 0;
        repeat (6) begin
            @(negedge Clk);
            if (ack) acks++;
        end
        n_assert++;
        if (acks !== 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        backdoor(16'h0100, 16'h0BAD);
        do_access("after_abort_read0", 1'b0, 16'h0000, 16'h1111, 16'h0, 16'h5555);
    endtask

    task automatic test_read_basic();
        backdoor(16'h3000, 16'hBEEF);
        do_access("read_3000", 1'b0, 16'h3000, 16'h0000, 16'h0, 16'h0000);
    endtask

    task automatic test_write_readback();
        do_access("write_1234", 1'b1, 16'h1234, 16'hA5A5, 16'h0, 16'h0000);
        do_access("readback_1234", 1'b0, 16'h1234, 16'h0000, 16'h0, 16'h0000);
    endtask

    task automatic test_mar_change();
        backdoor(16'h3000, 16'h1357);
        backdoor(16'h4000, 16'h2468);
        do_access("mar_change", 1'b0, 16'h3000, 16'h0000, 16'h0, 16'h4000);
    endtask

    task automatic test_back_to_back();
        int acks, idle_c, spacing_bad;
        int period;
        period = WS + 3;
        acks = 0; idle_c = 0; spacing_bad = 0;
        backdoor(16'h2222, 16'hC0DE);
        @(negedge Clk);
        req = 1'b1; we = 1'b0; MAR = 16'h2222;
        for (int k = 1; k <= 4 * period; k++) begin
            @(negedge Clk);
            if (ack) begin
                acks++;
                if (k !== (WS + 2) + (acks - 1) * period) spacing_bad++;
            end
            if (!busy) idle_c++;
        end
        req = 1'b0;
        exp_dout = exp_rd(16'h2222);
        @(negedge Clk);
        n_assert++;
        if (acks !== 4) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 4", acks); end
        n_assert++;
        if (spacing_bad !== 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d misplaced acks want 0", spacing_bad); end
        n_assert++;
        if (idle_c !== 4) begin n_fail++; $display("FAIL b2b_idle_cycles: got %0d want 4", idle_c); end
        n_assert++;
        if (busy !== 1'b0 || Data_to_CPU !== exp_dout) begin
            n_fail++;
            $display("FAIL b2b_final: busy=%b cpu=%h want busy=0 cpu=%h", busy, Data_to_CPU, exp_dout);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 15)) << 8;
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            do_access("random", 1'($urandom_range(0, 1)), a, 16'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_mmio();
`ifdef SLC3_MMIO_EN
        do_access("mmio_read", 1'b0, 16'hFFFF, 16'h0000, 16'h00C3, 16'h0000);
        do_access("mmio_write", 1'b1, 16'hFFFF, 16'h0042, 16'h0000, 16'h0000);
`else
        do_access("ffff_write", 1'b1, 16'hFFFF, 16'h0042, 16'h0000, 16'h0000);
        n_assert++;
        if (sram[16'hFFFF] !== 16'h0042) begin n_fail++; $display("FAIL ffff_in_sram: got %h want 0042", sram[16'hFFFF]); end
        do_access("ffff_read", 1'b0, 16'hFFFF, 16'h0000, 16'h00C3, 16'h0000);
`endif
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_read_basic();
        test_write_readback();
        test_mar_change();
        test_back_to_back();
        test_random();
        test_mmio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
